// File: rtl/perceptron_classifier.sv
// perceptron_classifier: two-stage inference pipeline that classifies (x1, x2) samples with captured weights.
// Optional macro PCLS_ERRCNT_EN pipelines t_in alongside each sample and counts label mismatches in err_cnt.
module perceptron_classifier #(
   parameter int XW   = 7,
   parameter int WW   = 14,
   parameter int CNTW = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ld_weights,
   input  logic signed [WW-1:0] W1,
   input  logic signed [WW-1:0] W2,
   input  logic signed [WW-1:0] Bias,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [XW-1:0] x1,
   input  logic signed [XW-1:0] x2,
   input  logic [1:0]           t_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           y,
   output logic signed [WW+8:0] y_sum,
   output logic                 armed,
   output logic [CNTW-1:0]      res_cnt,
   output logic [CNTW-1:0]      err_cnt
);
   localparam int PW = WW + XW;
   localparam int SW = WW + 9;

   logic signed [WW-1:0] w1_q, w2_q, bias_q;
   logic                 armed_q;
   logic                 s1_v, s2_v;
   logic signed [PW-1:0] p1_q, p2_q;
   logic [1:0]           y_q;
   logic signed [SW-1:0] sum_q;
   logic [CNTW-1:0]      res_q;

   logic                 ld_acc, s1_adv, accept, consume;
   logic signed [PW-1:0] prod1, prod2;
   logic signed [SW-1:0] sum_c;

   // Handshake decode and the arithmetic for both stages.
   always_comb begin
      ld_acc   = ld_weights & ~s1_v & ~s2_v;
      s1_adv   = ~s2_v | out_ready;
      in_ready = armed_q & ~ld_weights & (~s1_v | s1_adv);
      accept   = in_valid & in_ready;
      consume  = s2_v & out_ready;
      prod1    = PW'(x1) * PW'(w1_q);
      prod2    = PW'(x2) * PW'(w2_q);
      sum_c    = SW'(p1_q) + SW'(p2_q) + (SW'(bias_q) <<< 4);
   end

   // Weight shadow registers, pipeline stages and the result counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w1_q    <= '0;
         w2_q    <= '0;
         bias_q  <= '0;
         armed_q <= 1'b0;
         s1_v    <= 1'b0;
         s2_v    <= 1'b0;
         p1_q    <= '0;
         p2_q    <= '0;
         y_q     <= 2'b00;
         sum_q   <= '0;
         res_q   <= '0;
      end else begin
         if (ld_acc) begin
            w1_q    <= W1;
            w2_q    <= W2;
            bias_q  <= Bias;
            armed_q <= 1'b1;
         end

         if (accept) begin
            p1_q <= prod1;
            p2_q <= prod2;
            s1_v <= 1'b1;
         end else if (s1_adv) begin
            s1_v <= 1'b0;
         end

         // Output registers only change when new data arrives, so they hold under backpressure.
         if (s1_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
               sum_q <= sum_c;
               y_q   <= sum_c[SW-1] ? 2'b11 : 2'b01;
            end
         end

         if (ld_acc)
            res_q <= '0;
         else if (consume && res_q != '1)
            res_q <= res_q + CNTW'(1);
      end
   end

`ifdef PCLS_ERRCNT_EN
   logic [1:0]      t_s1, t_s2;
   logic [CNTW-1:0] err_q;

   // Label travels with its sample so the mismatch check lines up with the emerging result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_s1  <= 2'b00;
         t_s2  <= 2'b00;
         err_q <= '0;
      end else begin
         if (accept)
            t_s1 <= t_in;
         if (s1_adv && s1_v)
            t_s2 <= t_s1;
         if (ld_acc)
            err_q <= '0;
         else if (consume && y_q != t_s2 && err_q != '1)
            err_q <= err_q + CNTW'(1);
      end
   end

   assign err_cnt = err_q;
`else
   logic [1:0] unused_t_in;
   assign unused_t_in = t_in;
   assign err_cnt     = '0;
`endif

   assign out_valid = s2_v;
   assign y         = y_q;
   assign y_sum     = sum_q;
   assign armed     = armed_q;
   assign res_cnt   = res_q;

endmodule

// File: tb/tb_perceptron_classifier.sv
// tb_perceptron_classifier: directed scoreboard bench for perceptron_classifier.
// Expected results are queued on accept and compared as the DUT presents them; honours PCLS_ERRCNT_EN.
module tb_perceptron_classifier;
   localparam int XW   = 7;
   localparam int WW   = 14;
   localparam int CNTW = 16;
   localparam int SW   = WW + 9;
`ifdef PCLS_ERRCNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 ld_weights;
   logic signed [WW-1:0] W1, W2, Bias;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [XW-1:0] x1, x2;
   logic [1:0]           t_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [1:0]           y;
   logic signed [SW-1:0] y_sum;
   logic                 armed;
   logic [CNTW-1:0]      res_cnt;
   logic [CNTW-1:0]      err_cnt;

   typedef struct {
      logic [1:0]           y;
      logic signed [SW-1:0] sum;
      logic [1:0]           t;
   } exp_t;

   exp_t                 exp_q[$];
   int                   checks   = 0;
   int                   failures = 0;
   logic signed [WW-1:0] m_w1, m_w2, m_b;
   int                   m_res = 0;
   int                   m_err = 0;

   perceptron_classifier #(.XW(XW), .WW(WW), .CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n), .ld_weights(ld_weights),
      .W1(W1), .W2(W2), .Bias(Bias),
      .in_valid(in_valid), .in_ready(in_ready),
      .x1(x1), .x2(x2), .t_in(t_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .y_sum(y_sum), .armed(armed),
      .res_cnt(res_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model in plain integer arithmetic on the loaded weights.
   function automatic exp_t model(input logic signed [XW-1:0] a, input logic signed [XW-1:0] b,
                                  input logic [1:0] t);
      exp_t e;
      int   s;
      s     = int'(a) * int'(m_w1) + int'(b) * int'(m_w2) + int'(m_b) * 16;
      e.sum = SW'(s);
      e.y   = (s < 0) ? 2'b11 : 2'b01;
      e.t   = t;
      return e;
   endfunction

   // Scoreboard: checks the presented result every cycle and retires it when consumed.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            check_output("spurious_out_valid", {31'd0, out_valid}, 32'd0);
         end else begin
            check_output("y", {30'd0, y}, {30'd0, exp_q[0].y});
            check_output("y_sum", y_sum, exp_q[0].sum);
            if (out_ready) begin
               if (ERR_EN && exp_q[0].y != exp_q[0].t)
                  m_err++;
               m_res++;
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic apply_stimulus(input logic signed [XW-1:0] a, input logic signed [XW-1:0] b,
                                 input logic [1:0] t);
      int n;
      n        = 0;
      in_valid = 1'b1;
      x1       = a;
      x2       = b;
      t_in     = t;
      @(negedge clk);
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready)
         check_output("accept_timeout", {31'd0, in_ready}, 32'd1);
      else
         exp_q.push_back(model(a, b, t));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic load_weights(input logic signed [WW-1:0] a, input logic signed [WW-1:0] b,
                               input logic signed [WW-1:0] c);
      ld_weights = 1'b1;
      W1         = a;
      W2         = b;
      Bias       = c;
      @(posedge clk);
      #1;
      ld_weights = 1'b0;
      m_w1       = a;
      m_w2       = b;
      m_b        = c;
      m_res      = 0;
      m_err      = 0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0)
         check_output("drain_timeout", exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   logic signed [XW-1:0] bp_a[6] = '{7'h10, 7'h70, 7'h08, 7'h3F, 7'h40, 7'h01};
   logic signed [XW-1:0] bp_b[6] = '{7'h10, 7'h04, 7'h78, 7'h41, 7'h3F, 7'h7E};

   initial begin
      int   idx;
      int   n;
      exp_t e;
      rst_n      = 1'b0;
      ld_weights = 1'b0;
      W1 = '0; W2 = '0; Bias = '0;
      in_valid = 1'b0;
      x1 = '0; x2 = '0; t_in = 2'b00;
      out_ready = 1'b1;
      m_w1 = '0; m_w2 = '0; m_b = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state and gating without any load.
      @(negedge clk);
      check_output("rst_armed", {31'd0, armed}, 32'd0);
      check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_output("rst_y", {30'd0, y}, 32'd0);
      check_output("rst_y_sum", y_sum, 0);
      check_output("rst_res_cnt", res_cnt, 32'd0);
      check_output("rst_err_cnt", err_cnt, 32'd0);
      in_valid = 1'b1;
      x1       = 7'h10;
      repeat (3) @(negedge clk);
      check_output("gate_in_ready", {31'd0, in_ready}, 32'd0);
      check_output("gate_armed", {31'd0, armed}, 32'd0);
      check_output("gate_y", {30'd0, y}, 32'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;

      // Basic classification and latency.
      load_weights(14'h0100, 14'h0000, 14'h0000);
      @(negedge clk);
      check_output("load_armed", {31'd0, armed}, 32'd1);
      check_output("load_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      apply_stimulus(7'h10, 7'h00, 2'b01);
      @(negedge clk);
      check_output("lat_edge_n", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check_output("lat_edge_n1", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
      apply_stimulus(7'h70, 7'h00, 2'b11);
      drain();
      check_output("basic_res_cnt", res_cnt, m_res);

      // Bias and zero-sum boundary, plus the value just below zero.
      load_weights(14'h0100, 14'h0100, 14'h3F40);
      apply_stimulus(7'h08, 7'h04, 2'b01);
      apply_stimulus(7'h07, 7'h04, 2'b11);
      drain();
      check_output("bias_res_cnt", res_cnt, m_res);

      // Backpressure: only two samples fit while the sink stalls.
      load_weights(14'h0100, 14'h0080, 14'h0010);
      out_ready = 1'b0;
      idx       = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1;
         x1 = bp_a[idx]; x2 = bp_b[idx];
         e    = model(bp_a[idx], bp_b[idx], 2'b00);
         t_in = e.y;
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            idx++;
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check_output("bp_accepts", idx, 32'd2);
      check_output("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      #1;
      check_output("bp_in_ready_comb", {31'd0, in_ready}, 32'd1);
      n = 0;
      while (idx < 6 && n < 40) begin
         in_valid = 1'b1;
         x1 = bp_a[idx]; x2 = bp_b[idx];
         e    = model(bp_a[idx], bp_b[idx], 2'b00);
         t_in = e.y;
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            idx++;
         end
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (idx < 6)
         check_output("bp_stream_timeout", idx, 32'd6);
      drain();
      check_output("bp_res_cnt", res_cnt, 32'd6);
      check_output("bp_err_cnt", err_cnt, m_err);

      // Error counter: third label is wrong.
      load_weights(14'h0100, 14'h0000, 14'h0000);
      apply_stimulus(7'h10, 7'h00, 2'b01);
      apply_stimulus(7'h70, 7'h00, 2'b11);
      apply_stimulus(7'h20, 7'h00, 2'b11);
      apply_stimulus(7'h00, 7'h00, 2'b01);
      drain();
      check_output("err_res_cnt", res_cnt, 32'd4);
      check_output("err_cnt", err_cnt, m_err);
      check_output("err_cnt_expect", m_err, ERR_EN ? 32'd1 : 32'd0);

      // Busy load: ignored while stage 1 holds a sample.
      out_ready = 1'b0;
      apply_stimulus(7'h18, 7'h05, 2'b01);
      ld_weights = 1'b1;
      W1 = 14'h0200; W2 = 14'h0200; Bias = 14'h0100;
      @(posedge clk);
      #1;
      ld_weights = 1'b0;
      check_output("busy_res_cnt", res_cnt, m_res);
      check_output("busy_err_cnt", err_cnt, m_err);
      check_output("busy_armed", {31'd0, armed}, 32'd1);
      out_ready = 1'b1;
      drain();
      apply_stimulus(7'h68, 7'h05, 2'b11);
      drain();
      check_output("busy_res_cnt_after", res_cnt, m_res);

      // Mid-stream reset.
      out_ready = 1'b0;
      apply_stimulus(7'h10, 7'h00, 2'b01);
      apply_stimulus(7'h70, 7'h00, 2'b11);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_output("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      check_output("mrst_armed", {31'd0, armed}, 32'd0);
      check_output("mrst_in_ready", {31'd0, in_ready}, 32'd0);
      check_output("mrst_y", {30'd0, y}, 32'd0);
      check_output("mrst_res_cnt", res_cnt, 32'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check_output("mrst_in_ready_after", {31'd0, in_ready}, 32'd0);
      check_output("mrst_out_valid_after", {31'd0, out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
